// File: rtl/prescaler_bank.sv
// Multi-channel programmable clock-enable generator: each channel divides the
// system clock by a runtime divisor, handed over at the channel's wrap point.
module prescaler_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      sync_clr,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic [CHANNELS-1:0]       mode_sq,
  output logic [CHANNELS-1:0]       div_busy,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_out
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;
    logic             apply;

    // A divisor of 0 behaves as 1, so the terminal count never underflows.
    assign last_cnt = (act_q == '0) ? '0 : act_q - CNT_W'(1);
    assign wrap     = (cnt_q == last_cnt);
    // Idle channels (enable low) have no period to protect and take the new divisor at once.
    assign apply    = busy_q && !sync_clr && (wrap || !enable);

    always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      act_d  = act_q;
      shd_d  = shd_q;
      busy_d = busy_q;

      if (sync_clr) begin
        cnt_d = '0;
        sq_d  = 1'b0;
      end else if (enable) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A load on the wrap edge only captures; the apply waits for the next wrap.
      if (div_load[gi]) begin
        shd_d  = div_in[gi*CNT_W +: CNT_W];
        busy_d = 1'b1;
      end else if (apply) begin
        act_d  = shd_q;
        busy_d = 1'b0;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        act_q  <= DefDiv;
        shd_q  <= DefDiv;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        busy_q <= busy_d;
      end
    end

    assign div_busy[gi] = busy_q;
    assign tick[gi]     = tick_q;
    assign clk_out[gi]  = mode_sq[gi] ? sq_q : tick_q;
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Bench for prescaler_bank: directed scenarios plus randomized traffic, all
// compared cycle by cycle against an arithmetic model of the divider channels.
`timescale 1ns/1ps
module tb_prescaler_bank;
  localparam int CH = 4;
  localparam int W  = 32;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            sync_clr;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0]   div_load;
  logic [CH-1:0]   mode_sq;
  logic [CH-1:0]   div_busy;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   clk_out;

  int errors = 0;
  int checks = 0;

  // Model: edges elapsed in the current period, active/pending divisors, outputs.
  longint m_elapsed[CH];
  longint m_div[CH];
  longint m_shd[CH];
  bit     m_pend[CH];
  bit     m_tick[CH];
  bit     m_sq[CH];

  prescaler_bank #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .sync_clr(sync_clr),
    .div_in  (div_in),
    .div_load(div_load),
    .mode_sq (mode_sq),
    .div_busy(div_busy),
    .tick    (tick),
    .clk_out (clk_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_elapsed[i] = 0;
      m_div[i]     = 16;
      m_shd[i]     = 16;
      m_pend[i]    = 1'b0;
      m_tick[i]    = 1'b0;
      m_sq[i]      = 1'b0;
    end
  endtask

  // One rising edge worth of behaviour, using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      longint period  = (m_div[i] == 0) ? 1 : m_div[i];
      bit     wrapped = 1'b0;
      bit     pending = m_pend[i];
      if (sync_clr) begin
        m_elapsed[i] = 0;
        m_tick[i]    = 1'b0;
        m_sq[i]      = 1'b0;
      end else if (enable) begin
        if (m_elapsed[i] + 1 == period) begin
          wrapped      = 1'b1;
          m_elapsed[i] = 0;
          m_tick[i]    = 1'b1;
          m_sq[i]      = !m_sq[i];
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1;
          m_tick[i]    = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
      if (div_load[i]) begin
        m_shd[i]  = longint'(div_in[i*W +: W]);
        m_pend[i] = 1'b1;
      end else if (pending && !sync_clr && (wrapped || !enable)) begin
        m_div[i]  = m_shd[i];
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [CH-1:0] et, eb, ec;
    for (int i = 0; i < CH; i++) begin
      et[i] = m_tick[i];
      eb[i] = m_pend[i];
      ec[i] = mode_sq[i] ? m_sq[i] : m_tick[i];
    end
    check({tag, "_tick"}, 32'(tick), 32'(et));
    check({tag, "_busy"}, 32'(div_busy), 32'(eb));
    check({tag, "_clk_out"}, 32'(clk_out), 32'(ec));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    sync_clr = 1'b0;
    div_in   = '0;
    div_load = '0;
    mode_sq  = '0;
    model_reset();
    #2;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(div_busy), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    mode_sq = 4'b0001;

    // Default divisor on ch0, mid-period load on ch1, wrap-coincident load on ch2.
    for (int n = 1; n <= 48; n++) begin
      div_load = '0;
      if (n == 3) begin
        div_load[1]        = 1'b1;
        div_in[1*W +: W]   = 32'd4;
      end
      if (n == 16) begin
        div_load[2]        = 1'b1;
        div_in[2*W +: W]   = 32'd3;
      end
      cyc("dir");
      case (n)
        3:  check("t2_busy_set", 32'(div_busy[1]), 32'd1);
        15: check("t1_tick15", 32'(tick[0]), 32'd0);
        16: begin
          check("t1_tick16", 32'(tick[0]), 32'd1);
          check("t1_sq16", 32'(clk_out[0]), 32'd1);
          check("t2_apply16", 32'(div_busy[1]), 32'd0);
          check("t3_capture16", 32'(div_busy[2]), 32'd1);
        end
        17: check("t1_tick17", 32'(tick[0]), 32'd0);
        19: check("t2_tick19", 32'(tick[1]), 32'd0);
        20: check("t2_tick20", 32'(tick[1]), 32'd1);
        24: check("t2_tick24", 32'(tick[1]), 32'd1);
        32: begin
          check("t1_tick32", 32'(tick[0]), 32'd1);
          check("t1_sq32", 32'(clk_out[0]), 32'd0);
          check("t3_tick32", 32'(tick[2]), 32'd1);
          check("t3_apply32", 32'(div_busy[2]), 32'd0);
        end
        34: check("t3_tick34", 32'(tick[2]), 32'd0);
        35: check("t3_tick35", 32'(tick[2]), 32'd1);
        48: begin
          check("t1_tick48", 32'(tick[0]), 32'd1);
          check("t1_sq48", 32'(clk_out[0]), 32'd1);
        end
        default: ;
      endcase
    end
    div_load = '0;

    // Divisor 0 then 1 on ch3: continuous tick, square toggling every cycle.
    enable   = 1'b0;
    sync_clr = 1'b1;
    cyc("t4_clr");
    sync_clr         = 1'b0;
    div_in[3*W +: W] = 32'd0;
    div_load[3]      = 1'b1;
    cyc("t4_load0");
    div_load = '0;
    check("t4_busy_idle", 32'(div_busy[3]), 32'd1);
    cyc("t4_apply_idle");
    check("t4_applied_idle", 32'(div_busy[3]), 32'd0);
    enable     = 1'b1;
    mode_sq[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc("t4_run0");
      check("t4_tick_d0", 32'(tick[3]), 32'd1);
      check("t4_toggle_d0", 32'(clk_out[3]), 32'(k % 2));
    end
    div_in[3*W +: W] = 32'd1;
    div_load[3]      = 1'b1;
    cyc("t4_load1");
    div_load = '0;
    check("t4_busy_d1", 32'(div_busy[3]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc("t4_run1");
      check("t4_tick_d1", 32'(tick[3]), 32'd1);
    end

    // Hold with enable low at cnt=7 on ch0.
    sync_clr = 1'b1;
    cyc("t5_clr");
    sync_clr = 1'b0;
    for (int k = 0; k < 7; k++) cyc("t5_pre");
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc("t5_hold");
      check("t5_hold_tick", 32'(tick[0]), 32'd0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc("t5_resume");
      check("t5_resume_tick", 32'(tick[0]), 32'(k == 9));
    end

    // sync_clr keeps a pending load; async reset drops everything.
    mode_sq          = 4'hF;
    div_in[1*W +: W] = 32'd5;
    div_load[1]      = 1'b1;
    cyc("t6_load");
    div_load = '0;
    sync_clr = 1'b1;
    cyc("t6_clr");
    sync_clr = 1'b0;
    check("t6_clr_busy", 32'(div_busy[1]), 32'd1);
    check("t6_clr_tick", 32'(tick), 32'd0);
    check("t6_clr_clk_out", 32'(clk_out), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc("t6_run");
      if (k == 4) check("t6_apply_busy", 32'(div_busy[1]), 32'd0);
      if (k == 4 || k == 8 || k == 9) check("t6_tick", 32'(tick[1]), 32'(k != 8));
    end
    div_in[0*W +: W] = 32'd7;
    div_load[0]      = 1'b1;
    cyc("t6_preload");
    div_load = '0;
    reset_n  = 1'b0;
    #2;
    model_reset();
    check("t6_arst_tick", 32'(tick), 32'd0);
    check("t6_arst_busy", 32'(div_busy), 32'd0);
    check("t6_arst_clk_out", 32'(clk_out), 32'd0);
    @(posedge clock);
    #1;
    check_outputs("t6_in_reset");
    reset_n = 1'b1;
    mode_sq = '0;
    for (int k = 1; k <= 16; k++) begin
      cyc("t6_after");
      check("t6_default_div", 32'(tick), (k == 16) ? 32'hF : 32'h0);
    end

    // Randomized traffic with small divisors.
    for (int n = 0; n < 1500; n++) begin
      enable   = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < CH; i++) begin
        div_load[i]      = ($urandom_range(0, 19) == 0);
        div_in[i*W +: W] = 32'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) mode_sq = 4'($urandom_range(0, 15));
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
